// File: rtl/uart_rx_axis.sv
// Purpose: 8N1 UART receiver (LSB first) feeding a small byte FIFO with a valid/ready master port.
// Latency: about 9.5 bit times from the start-bit edge to m_axis_valid, plus 3 cycles for synchronizer and start detect.
// Backpressure: the FIFO absorbs bytes while m_axis_ready is low; a good byte arriving at a full FIFO with no pop is dropped and flagged on overrun.
//
// Ports:
//   clk, rst_n         system clock (rising edge), asynchronous active-low reset
//   rx                 asynchronous serial input, idles high
//   m_axis_data/valid  FIFO head byte and not-empty flag; m_axis_ready pops the head
//   frame_err          one-cycle pulse when a stop bit is sampled low
//   overrun            one-cycle pulse when a good byte is dropped at a full FIFO
//   rx_busy            receiver state machine is not idle
module uart_rx_axis #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_axis_data,
  output logic                 m_axis_valid,
  input  logic                 m_axis_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_q1, rx_s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;

  logic                 cnt_clr, shift_en, push_req, ferr_req;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          count;
  logic                 full, pop, push;

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!rx_s) state_nxt = S_START;
      S_START: if (cnt == CNT_MID) state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (cnt == CNT_LAST && bit_idx == BIT_LAST) state_nxt = S_STOP;
      // Leaving at mid stop bit lets a back-to-back start edge be caught.
      S_STOP:  if (cnt == CNT_LAST) state_nxt = rx_s ? S_IDLE : S_BREAK;
      // Held-low line: stay here so only one frame_err is raised.
      S_BREAK: if (rx_s) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    push_req = 1'b0;
    ferr_req = 1'b0;
    rx_busy  = (state != S_IDLE);
    case (state)
      S_IDLE:  cnt_clr = 1'b1;
      S_START: cnt_clr = (cnt == CNT_MID);
      S_DATA:  shift_en = (cnt == CNT_LAST);
      S_STOP: begin
        push_req = (cnt == CNT_LAST) & rx_s;
        ferr_req = (cnt == CNT_LAST) & ~rx_s;
      end
      S_BREAK: cnt_clr = 1'b1;
      default: cnt_clr = 1'b1;
    endcase
  end

  // Bit-period counter, data-bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (cnt_clr || cnt == CNT_LAST) cnt <= '0;
      else                            cnt <= cnt + CW'(1);

      if (state == S_START) bit_idx <= '0;
      else if (shift_en)    bit_idx <= bit_idx + BW'(1);

      // LSB arrives first, so shift in from the top.
      if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
    end
  end

  // FIFO. A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign full         = (count == CNT_FULL);
  assign m_axis_valid = (count != '0);
  assign m_axis_data  = mem[rd_ptr];
  assign pop          = m_axis_valid & m_axis_ready;
  assign push         = push_req & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
      frame_err <= ferr_req;
      overrun   <= push_req & full & ~pop;
    end
  end

endmodule
